// File: rtl/mem_stage.sv
// Purpose     : RISC-V MEM stage; runs loads/stores against a req/ack data memory and registers the MEM/WB boundary.
// Latency     : 1 cycle for non-memory ops and zero-wait accesses; +N cycles for N memory wait states.
// Backpressure: stall is high while an issued access has no ack; upstream holds its inputs until stall drops.
// Ports       : clk, rst (async, active-high); EX/MEM inputs in_valid, ALUresult, data2, memRead, memWrite,
//               funct3, regWrite, memToReg, rd; stall; data memory port dmem_req/we/addr/wdata/be/ack/rdata;
//               registered outputs wb_valid, wb_regWrite, wb_rd, wb_data, misalign.
// Option      : MEM_MISALIGN_TRAP_EN - misaligned H/W accesses are trapped (no request, misalign=1)
//               instead of being issued with their offending low address bits ignored.
module mem_stage #(
  parameter int WORD_BITWIDTH    = 32,
  parameter int REG_NUM_BITWIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WORD_BITWIDTH-1:0]    ALUresult,
  input  logic [WORD_BITWIDTH-1:0]    data2,
  input  logic                        memRead,
  input  logic                        memWrite,
  input  logic [2:0]                  funct3,
  input  logic                        regWrite,
  input  logic                        memToReg,
  input  logic [REG_NUM_BITWIDTH-1:0] rd,
  output logic                        stall,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [WORD_BITWIDTH-1:0]    dmem_addr,
  output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
  output logic [3:0]                  dmem_be,
  input  logic                        dmem_ack,
  input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
  output logic                        wb_valid,
  output logic                        wb_regWrite,
  output logic [REG_NUM_BITWIDTH-1:0] wb_rd,
  output logic [WORD_BITWIDTH-1:0]    wb_data,
  output logic                        misalign
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state, state_nxt;

  // Request captured when the memory does not answer in the issuing cycle.
  logic [WORD_BITWIDTH-1:0]    lat_addr, lat_data;
  logic                        lat_we, lat_rw;
  logic [2:0]                  lat_f3;
  logic [REG_NUM_BITWIDTH-1:0] lat_rd;

  // Operation being worked on: live inputs in IDLE, captured copy in WAIT.
  logic [WORD_BITWIDTH-1:0]    op_addr, op_data;
  logic                        op_we, op_rw, op_mem;
  logic [2:0]                  op_f3;
  logic [REG_NUM_BITWIDTH-1:0] op_rd;

  logic                        mis_det, issue, mem_ack;
  logic [7:0]                  ld_byte;
  logic [15:0]                 ld_half;
  logic [WORD_BITWIDTH-1:0]    load_val;

  // memToReg is implied by memRead here; the load value always goes to wb_data.
  logic unused_mem_to_reg;
  assign unused_mem_to_reg = memToReg;

  assign op_mem  = (state == WAIT) ? 1'b1     : (in_valid & (memRead | memWrite));
  assign op_addr = (state == WAIT) ? lat_addr : ALUresult;
  assign op_data = (state == WAIT) ? lat_data : data2;
  assign op_we   = (state == WAIT) ? lat_we   : memWrite;
  assign op_rw   = (state == WAIT) ? lat_rw   : regWrite;
  assign op_f3   = (state == WAIT) ? lat_f3   : funct3;
  assign op_rd   = (state == WAIT) ? lat_rd   : rd;

`ifdef MEM_MISALIGN_TRAP_EN
  // Only checked at issue; a trapped access never reaches WAIT.
  assign mis_det = (state == IDLE) & op_mem &
                   (((op_f3[1:0] == 2'b01) & op_addr[0]) |
                    ((op_f3[1:0] == 2'b10) & (op_addr[1:0] != 2'b00)));
`else
  assign mis_det = 1'b0;
`endif

  assign issue     = op_mem & ~mis_det;
  // Reset masks the request even if the inputs present a memory op.
  assign dmem_req  = issue & ~rst;
  assign mem_ack   = dmem_req & dmem_ack;
  assign dmem_we   = dmem_req & op_we;
  assign dmem_addr = {op_addr[WORD_BITWIDTH-1:2], 2'b00};
  assign stall     = dmem_req & ~dmem_ack;

  // Store lane replication and byte enables; H ignores addr[0], W ignores addr[1:0].
  always_comb begin
    dmem_wdata = op_data;
    dmem_be    = 4'b1111;
    case (op_f3[1:0])
      2'b00: begin
        dmem_wdata = {(WORD_BITWIDTH/8){op_data[7:0]}};
        dmem_be    = 4'b0001 << op_addr[1:0];
      end
      2'b01: begin
        dmem_wdata = {(WORD_BITWIDTH/16){op_data[15:0]}};
        dmem_be    = 4'b0011 << {op_addr[1], 1'b0};
      end
      default: begin
        dmem_wdata = op_data;
        dmem_be    = 4'b1111;
      end
    endcase
  end

  // Load lane extraction with sign/zero extension.
  assign ld_byte = dmem_rdata[{op_addr[1:0], 3'b000} +: 8];
  assign ld_half = dmem_rdata[{op_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_val = dmem_rdata;
    case (op_f3)
      3'b000:  load_val = {{(WORD_BITWIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{(WORD_BITWIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  load_val = {{(WORD_BITWIDTH-8){1'b0}}, ld_byte};
      3'b101:  load_val = {{(WORD_BITWIDTH-16){1'b0}}, ld_half};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dmem_req & ~dmem_ack) state_nxt = WAIT;
      WAIT:    if (dmem_ack)             state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      lat_rw   <= 1'b0;
      lat_f3   <= 3'b000;
      lat_rd   <= '0;
    end else if ((state == IDLE) & issue & ~dmem_ack) begin
      lat_addr <= ALUresult;
      lat_data <= data2;
      lat_we   <= memWrite;
      lat_rw   <= regWrite;
      lat_f3   <= funct3;
      lat_rd   <= rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      misalign    <= 1'b0;
    end else if (!op_mem) begin
      wb_valid    <= in_valid;
      wb_regWrite <= in_valid & regWrite;
      wb_rd       <= rd;
      wb_data     <= ALUresult;
      misalign    <= 1'b0;
    end else if (mis_det) begin
      wb_valid    <= 1'b1;
      wb_regWrite <= 1'b0;
      wb_rd       <= rd;
      wb_data     <= ALUresult;
      misalign    <= 1'b1;
    end else if (mem_ack) begin
      wb_valid    <= 1'b1;
      wb_regWrite <= op_rw & ~op_we;
      wb_rd       <= op_rd;
      wb_data     <= op_we ? op_addr : load_val;
      misalign    <= 1'b0;
    end else begin
      // Waiting on memory: bubble into MEM/WB.
      wb_valid    <= 1'b0;
      misalign    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] ALUresult, data2;
  logic        memRead, memWrite;
  logic [2:0]  funct3;
  logic        regWrite, memToReg;
  logic [4:0]  rd;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_regWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ALUresult(ALUresult), .data2(data2),
    .memRead(memRead), .memWrite(memWrite), .funct3(funct3), .regWrite(regWrite),
    .memToReg(memToReg), .rd(rd), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign(misalign)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct { logic [4:0] rd; logic rw; logic [31:0] data; logic chk_data; logic mis; } wb_exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_exp_t;

  int checks = 0;
  int failures = 0;
  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  longint   acc_q[$];
  logic [31:0] mem [16];
  int force_wait = -1;
  int last_waits = 0;
  int req_count = 0;
  logic [31:0] last_req_addr = 0, last_req_wdata = 0;
  logic [3:0]  last_req_be = 0;
  logic        last_req_we = 0;
  logic [31:0] last_wb_data = 0;
  logic [4:0]  last_wb_rd = 0;
  logic        last_wb_rw = 0, last_wb_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: pure arithmetic on the architectural rules.
  function automatic logic mis_model(int kind, logic [2:0] f3, logic [31:0] a);
    logic m;
    m = (kind != 0) && (((f3[1:0] == 2'b01) && (a % 2 != 0)) || ((f3[1:0] == 2'b10) && (a % 4 != 0)));
    return TRAP && m;
  endfunction

  function automatic logic [31:0] load_model(logic [31:0] w, logic [2:0] f3, logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic store_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             output logic [3:0] be, output logic [31:0] wd);
    case (f3[1:0])
      2'b00:   begin be = 4'(1 << (a % 4));             wd = (d & 32'hFF) * 32'h0101_0101; end
      2'b01:   begin be = 4'(3 << (2 * ((a / 2) % 2))); wd = (d & 32'hFFFF) * 32'h0001_0001; end
      default: begin be = 4'hF;                         wd = d; end
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction is accepted.
  task automatic issue(input bit v, input int kind, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r, input bit rw, input int waits,
                       output int stalls);
    wb_exp_t e;
    req_exp_t q;
    bit mis, req_exp, st, accepted;
    int idx;
    in_valid = v; ALUresult = a; data2 = d; memRead = (kind == 1); memWrite = (kind == 2);
    funct3 = f3; regWrite = rw; memToReg = (kind == 1); rd = r; force_wait = waits;
    mis = mis_model(kind, f3, a);
    req_exp = v && (kind != 0) && !mis;
    idx = int'(a[5:2]);
    if (v) begin
      e.rd = r; e.mis = mis; e.chk_data = !mis;
      e.rw = (kind == 2 || mis) ? 1'b0 : rw;
      e.data = (kind == 1 && !mis) ? load_model(mem[idx], f3, a) : a;
      wb_q.push_back(e);
    end
    if (req_exp) begin
      q.addr = a & ~32'h3;
      q.we = (kind == 2);
      q.be = 4'h0; q.wdata = 32'h0;
      if (kind == 2) begin
        store_model(f3, a, d, q.be, q.wdata);
        for (int i = 0; i < 4; i++) if (q.be[i]) mem[idx][8*i +: 8] = q.wdata[8*i +: 8];
      end
      req_q.push_back(q);
    end
    stalls = 0; accepted = 0;
    for (int k = 0; k < 64 && !accepted; k++) begin
      #3;
      st = stall;
      @(posedge clk);
      if (!st) begin
        accepted = 1;
        if (v) acc_q.push_back($time);
      end else begin
        stalls++;
        #1;
      end
    end
    if (!accepted) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=stall_stuck required=accept_within_64");
    end
    #1;
    chk("stall_cycles", stalls, req_exp ? last_waits : 0);
  endtask

  task automatic drain();
    in_valid = 0; memRead = 0; memWrite = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Memory responder: random wait states, random ack noise while no request.
  initial begin
    bit busy;
    int waits_left;
    req_exp_t q;
    busy = 0; waits_left = 0;
    dmem_ack = 0; dmem_rdata = 0;
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        busy = 0; dmem_ack = 0;
      end else if (dmem_req) begin
        if (!busy) begin
          busy = 1;
          waits_left = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
          last_waits = waits_left;
          req_count++;
          last_req_addr = dmem_addr; last_req_be = dmem_be;
          last_req_wdata = dmem_wdata; last_req_we = dmem_we;
          if (req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_req actual=addr_0x%08h required=no_request", dmem_addr);
          end else begin
            q = req_q.pop_front();
            chk("req_addr", dmem_addr, q.addr);
            chk("req_we", dmem_we, q.we);
            if (q.we) begin
              chk("req_be", dmem_be, q.be);
              chk("req_wdata", dmem_wdata, q.wdata);
            end
          end
        end
        if (waits_left == 0) begin
          dmem_ack = 1; dmem_rdata = mem[dmem_addr[5:2]]; busy = 0;
        end else begin
          dmem_ack = 0; dmem_rdata = $urandom; waits_left--;
        end
      end else begin
        dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      end
    end
  end

  // Write-back monitor / scoreboard.
  initial begin
    wb_exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst && wb_valid) begin
        last_wb_data = wb_data; last_wb_rd = wb_rd; last_wb_rw = wb_regWrite; last_wb_mis = misalign;
        if (wb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wb actual=rd_%0d required=no_writeback", wb_rd);
        end else begin
          e = wb_q.pop_front();
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_regWrite", wb_regWrite, e.rw);
          chk("wb_misalign", misalign, e.mis);
          if (e.chk_data) chk("wb_data", wb_data, e.data);
          if (acc_q.size() > 0) chk("wb_latency", 32'($time - acc_q.pop_front()), 2);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, rc;
    logic [2:0] lf3 [5];
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h80FF_1234;

    // Reset state, request masked even with a load presented.
    rst = 1; in_valid = 1; memRead = 1; memWrite = 0; ALUresult = 32'h104; data2 = 0;
    funct3 = 3'b010; regWrite = 1; memToReg = 1; rd = 3;
    #3;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_regWrite", wb_regWrite, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_misalign", misalign, 0);
    in_valid = 0; memRead = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;

    // Reset asserted mid-WAIT with the load held on the inputs.
    in_valid = 1; memRead = 1; ALUresult = 32'h104; funct3 = 3'b010; force_wait = 20;
    req_q.push_back('{addr: 32'h104, we: 1'b0, be: 4'h0, wdata: 32'h0});
    repeat (3) @(posedge clk);
    #1;
    chk("wait_stall", stall, 1);
    rst = 1;
    #1;
    chk("rst_wait_req_drop", dmem_req, 0);
    chk("rst_wait_wb_valid", wb_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0; ALUresult = 32'h108;
    #1;
    chk("post_rst_wb_valid", wb_valid, 0);
    chk("post_rst_req_live", dmem_req, 1);
    chk("post_rst_idle_addr", dmem_addr, 32'h108);
    in_valid = 0; memRead = 0; force_wait = -1;
    @(posedge clk);
    #1;

    // ADD into rd=5.
    issue(1, 0, 3'b000, 32'h10, 32'h0, 5'd5, 1, -1, s);
    drain();
    chk("add_wb_data", last_wb_data, 32'h10);
    chk("add_wb_rd", last_wb_rd, 5);

    // LB at 0x103, two wait states.
    issue(1, 1, 3'b000, 32'h103, 32'h0, 5'd7, 1, 2, s);
    drain();
    chk("lb_stall_cycles", s, 2);
    chk("lb_wb_data", last_wb_data, 32'hFFFF_FF80);

    // LHU at 0x102, zero-wait.
    issue(1, 1, 3'b101, 32'h102, 32'h0, 5'd8, 1, 0, s);
    drain();
    chk("lhu_addr", last_req_addr, 32'h100);
    chk("lhu_wb_data", last_wb_data, 32'h0000_80FF);

    // LW at 0x102: trapped or issued with addr[1:0] ignored.
    rc = req_count;
    issue(1, 1, 3'b010, 32'h102, 32'h0, 5'd9, 1, 0, s);
    drain();
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lw_mis_flag", last_wb_mis, 1);
    chk("lw_mis_regWrite", last_wb_rw, 0);
    chk("lw_mis_no_req", req_count, rc);
`else
    chk("lw_req_count", req_count, rc + 1);
    chk("lw_addr", last_req_addr, 32'h100);
    chk("lw_wb_data", last_wb_data, 32'h80FF_1234);
`endif

    // SB 0xAB at 0x201.
    issue(1, 2, 3'b000, 32'h201, 32'h0000_00AB, 5'd4, 1, 0, s);
    drain();
    chk("sb_be", last_req_be, 4'b0010);
    chk("sb_wdata", last_req_wdata, 32'hABAB_ABAB);
    chk("sb_we", last_req_we, 1);
    chk("sb_wb_regWrite", last_wb_rw, 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      case (kind)
        1:       f3 = lf3[$urandom_range(0, 4)];
        2:       f3 = 3'($urandom_range(0, 2));
        default: f3 = 3'($urandom);
      endcase
      issue($urandom_range(0, 7) != 0, kind, f3, $urandom, $urandom, 5'($urandom),
            1'($urandom_range(0, 1)), -1, s);
      if ($urandom_range(0, 9) == 0) drain();
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("wb_queue_empty", wb_q.size(), 0);
    chk("req_queue_empty", req_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
